// File: rtl/fir_mac_filter.sv
// Time-multiplexed FIR filter: one MAC per clock over a runtime tap count, one output per input sample.
// Define FIR_SATURATE_EN to clamp results to the DATA_W range (and drive Clipped); otherwise results wrap.
module fir_mac_filter #(
    parameter int DATA_W = 24,
    parameter int COEF_W = 16,
    parameter int TAPS   = 32
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic [DATA_W-1:0]         SampleIn,
    input  logic                      SampleValid,
    output logic                      SampleReady,
    input  logic [$clog2(TAPS):0]     TapCount,
    input  logic                      CoefWrite,
    input  logic [$clog2(TAPS)-1:0]   CoefAddr,
    input  logic [COEF_W-1:0]         CoefData,
    output logic                      CoefWriteErr,
    output logic [DATA_W-1:0]         SampleOut,
    output logic                      OutValid,
    output logic                      Clipped
);

    localparam int AW     = $clog2(TAPS);
    localparam int CW     = AW + 1;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + AW;

    localparam logic [CW-1:0] TAPS_N = CW'(TAPS);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] MAC   = 2'd1;
    localparam logic [1:0] ROUND = 2'd2;

    logic [1:0]               state;
    logic [AW-1:0]            wp;
    logic [CW-1:0]            tapN;
    logic [CW-1:0]            k;
    logic signed [ACC_W-1:0]  acc;
    logic signed [DATA_W-1:0] hist [TAPS];
    logic signed [COEF_W-1:0] coef [TAPS];

    logic [DATA_W-1:0]        sampleOutR;
    logic                     outValidR;
    logic                     coefWriteErrR;

    logic                     accept;
    logic                     coefWrEn;
    logic [CW-1:0]            tapSel;
    logic [AW-1:0]            macIdx;
    logic signed [PROD_W-1:0] prod;
    logic [DATA_W-1:0]        roundOut;

`ifdef FIR_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    logic signed [ACC_W-1:0]  rnd;
    logic                     roundClip;
    logic                     clippedR;
`endif

    assign SampleReady  = (state == IDLE) && Reset;
    assign accept       = SampleValid && SampleReady;
    assign coefWrEn     = CoefWrite && SampleReady;
    assign macIdx       = wp - k[AW-1:0];
    assign CoefWriteErr = coefWriteErrR;
    assign SampleOut    = sampleOutR;
    assign OutValid     = outValidR;

    // Tap count of zero or beyond the history depth means "use every tap".
    always_comb begin
        tapSel = TapCount;
        if ((TapCount == CW'(0)) || (TapCount > TAPS_N)) begin
            tapSel = TAPS_N;
        end else begin
            tapSel = TapCount;
        end
    end

    // Product of the k-th newest history sample and coefficient k.
    always_comb begin
        prod = hist[macIdx] * coef[k[AW-1:0]];
    end

`ifdef FIR_SATURATE_EN
    // Floor-scale the accumulator back to sample range and clamp.
    always_comb begin
        rnd       = acc >>> (COEF_W - 1);
        roundOut  = rnd[DATA_W-1:0];
        roundClip = 1'b0;
        if (rnd > SAT_HI) begin
            roundOut  = SAT_HI[DATA_W-1:0];
            roundClip = 1'b1;
        end else if (rnd < SAT_LO) begin
            roundOut  = SAT_LO[DATA_W-1:0];
            roundClip = 1'b1;
        end else begin
            roundOut  = rnd[DATA_W-1:0];
            roundClip = 1'b0;
        end
    end

    assign Clipped = clippedR;
`else
    // Floor-scale with two's-complement wrap: the low DATA_W bits above the Q fraction.
    always_comb begin
        roundOut = acc[COEF_W-1 +: DATA_W];
    end

    assign Clipped = 1'b0;
`endif

    // Coefficient RAM survives reset; writes only land while the block is idle.
    always_ff @(posedge Clock) begin
        if (coefWrEn) begin
            coef[CoefAddr] <= CoefData;
        end
    end

    // Circular sample history, cleared on reset so an aborted run leaves nothing stale.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < TAPS; i++) begin
                hist[i] <= '0;
            end
        end else if (accept) begin
            hist[wp] <= SampleIn;
        end
    end

    // Control FSM, accumulator and registered outputs.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state         <= IDLE;
            wp            <= '0;
            tapN          <= '0;
            k             <= '0;
            acc           <= '0;
            sampleOutR    <= '0;
            outValidR     <= 1'b0;
            coefWriteErrR <= 1'b0;
`ifdef FIR_SATURATE_EN
            clippedR      <= 1'b0;
`endif
        end else begin
            outValidR     <= 1'b0;
            coefWriteErrR <= CoefWrite && (state != IDLE);
`ifdef FIR_SATURATE_EN
            clippedR      <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (accept) begin
                        tapN  <= tapSel;
                        acc   <= '0;
                        k     <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc + {{AW{prod[PROD_W-1]}}, prod};
                    k   <= k + CW'(1);
                    if (k == (tapN - CW'(1))) begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    sampleOutR <= roundOut;
                    outValidR  <= 1'b1;
`ifdef FIR_SATURATE_EN
                    clippedR   <= roundClip;
`endif
                    wp         <= wp + AW'(1);
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
